mux_scan_nx1: RTL and testbench

Parametrised N-to-1 bit multiplexer with a registered output, manual or automatic-scan channel selection, and a one-cycle channel-change strobe. It is the sequential successor to the team's combinational 2:1 mux and sits directly in the Tiny Tapeout user slot. Data channels arrive on `ui_in` and control arrives on `uio_in`. The selected bit and the current channel index are driven on `uo_out`.

---
 rtl/mux_scan_nx1.sv | 102 ++++++++++
 tb/tb_mux_scan_nx1.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nx1.sv
// N-to-1 bit mux with registered output, manual or auto-scan channel select and a channel-change strobe.
// Optional macro MUX_SYNC_EN inserts a two-flop synchronizer on each used data input.
module mux_scan_nx1 #(
    parameter int NUM_CH   = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int         SEL_W    = $clog2(NUM_CH);
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic              y_q, y_d;
    logic              chg_q, chg_d;
    logic              mode_q, mode_d;
    logic [NUM_CH-1:0] data;

    logic              auto_mode, hold;
    logic [SEL_W-1:0]  man_sel;

    assign auto_mode = uio_in[4];
    assign hold      = uio_in[5];
    assign man_sel   = uio_in[SEL_W-1:0];

`ifdef MUX_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = ui_in[NUM_CH-1:0];
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign data = sync2_q;
`else
    assign data = ui_in[NUM_CH-1:0];
`endif

    // A manual->auto transition restarts the dwell counter even when hold is set.
    always_comb begin
        idx_d     = idx_q;
        div_cnt_d = div_cnt_q;
        mode_d    = auto_mode;
        if (!auto_mode) begin
            idx_d     = man_sel;
            div_cnt_d = 8'd0;
        end else if (!mode_q) begin
            div_cnt_d = 8'd0;
        end else if (!hold) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = 8'd0;
                idx_d     = idx_q + SEL_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
        y_d   = data[idx_q];
        chg_d = (idx_d != idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            div_cnt_q <= 8'd0;
            y_q       <= 1'b0;
            chg_q     <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            div_cnt_q <= div_cnt_d;
            y_q       <= y_d;
            chg_q     <= chg_d;
            mode_q    <= mode_d;
        end
    end

    assign uo_out  = {3'b000, chg_q, 3'(idx_q), y_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in};

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Scoreboard bench for mux_scan_nx1 (default build: NUM_CH=8, SCAN_DIV=4, no input synchronizer).
module tb_mux_scan_nx1;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    mux_scan_nx1 #(.NUM_CH(8), .SCAN_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: after each rising edge, compare outputs against entries due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (uo_out !== e.val) begin
                n_fail++;
                $display("FAIL %s @%0d: uo_out got %h, expected %h", e.name, cyc, uo_out, e.val);
            end
            n_chk++;
            if ({uio_oe, uio_out} !== 16'h0000) begin
                n_fail++;
                $display("FAIL %s_uio @%0d: uio_oe/uio_out got %h, expected 0000", e.name, cyc, {uio_oe, uio_out});
            end
        end
    end

    initial begin
        logic [7:0] data;
        logic [2:0] idx_e, idx_n;
        logic       chg_e;
        int         budget;

        ena    = 1'b1;
        rst_n  = 1'b0;
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        push(1, 8'h00, "reset1");
        push(2, 8'h00, "reset2");
        tick(2);

        // Release in manual mode, select 0: y follows ui_in[0]=1
        rst_n = 1'b1;
        push(3, 8'h01, "rel_y");
        tick(1);

        // Manual select 2 then 3 with data 1010_0100
        ui_in  = 8'b1010_0100;
        uio_in = 8'h02;
        push(4, 8'h14, "sel2_chg");
        push(5, 8'h05, "sel2_y");
        tick(2);
        uio_in = 8'h03;
        push(6, 8'h17, "sel3_chg");
        push(7, 8'h06, "sel3_y");
        for (int c = 8; c <= 16; c++) push(c, 8'h06, "sel3_hold");
        tick(11);

        // Data latency: raise channel 3
        ui_in = 8'hAC;
        push(17, 8'h07, "dlat");
        push(18, 8'h07, "dlat_s");
        push(19, 8'h07, "dlat_s");
        tick(3);

        // Manual select 5, then enter auto-scan from idx 5
        uio_in = 8'h05;
        push(20, 8'h1B, "sel5_chg");
        push(21, 8'h0B, "sel5_y");
        tick(2);
        uio_in = 8'h15;
        data   = 8'hAC;
        idx_e  = 3'd5;
        for (int e = 22; e <= 56; e++) begin
            chg_e = (e > 22) && (((e - 22) % 4) == 0);
            idx_n = chg_e ? idx_e + 3'd1 : idx_e;
            push(e, {3'b000, chg_e, idx_n, data[idx_e]}, "scan");
            idx_e = idx_n;
        end
        tick(35);

        // Hold at div_cnt=2 for 10 cycles, idx=5
        uio_in = 8'h35;
        for (int c = 57; c <= 66; c++) push(c, 8'h0B, "hold");
        tick(10);
        uio_in = 8'h15;
        push(67, 8'h0B, "unhold1");
        push(68, 8'h1D, "unhold_adv");
        push(69, 8'h0C, "unhold_y");
        push(70, 8'h0C, "unhold3");
        tick(4);

        // Reset mid-scan at idx=6
        rst_n = 1'b0;
        push(71, 8'h00, "midrst");
        tick(1);
        rst_n = 1'b1;
        for (int c = 72; c <= 75; c++) push(c, 8'h00, "rst_dwell");
        push(76, 8'h12, "rst_adv");
        push(77, 8'h02, "rst_y");
        tick(6);

        // Auto->manual loads select on same edge; hold ignored in manual
        uio_in = 8'h23;
        push(78, 8'h16, "a2m_chg");
        push(79, 8'h07, "a2m_y");
        tick(2);

        // Mode change with hold set: counter restarts, then hold freezes
        uio_in = 8'h33;
        for (int c = 80; c <= 84; c++) push(c, 8'h07, "m2a_hold");
        tick(5);
        // Release with a different manual select, which auto mode ignores
        uio_in = 8'h17;
        for (int c = 85; c <= 87; c++) push(c, 8'h07, "m2a_dwell");
        push(88, 8'h19, "m2a_adv");
        push(89, 8'h08, "m2a_y");
        tick(5);

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
